// File: rtl/k_muldiv_pkg.sv
// k_muldiv_pkg: op encodings, FSM states and iteration count shared by the multiply/divide unit.
package k_muldiv_pkg;
  typedef enum logic [1:0] {OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIX} state_e;
  localparam int ITERS = 32;
endpackage

// File: rtl/k_mult_div_unit_if.sv
// k_mult_div_unit_if: operand/handshake/HI-LO bundle between control logic and the multiply/divide unit.
interface k_mult_div_unit_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] K_in1, K_in2, mt_data, hi, lo;
  logic [1:0] op;
  logic start, mt_hi, mt_lo, busy, done;
  modport master(output K_in1, K_in2, start, op, mt_hi, mt_lo, mt_data, input busy, done, hi, lo);
  modport slave(input K_in1, K_in2, start, op, mt_hi, mt_lo, mt_data, output busy, done, hi, lo);
endinterface

// File: rtl/k_muldiv_step.sv
// k_muldiv_step: one shift-add multiply or restoring shift-subtract divide iteration on the 64-bit working register.
module k_muldiv_step #(parameter int WIDTH = 32) (
  input  logic [2*WIDTH-1:0] work,
  input  logic [WIDTH-1:0]   mag,
  input  logic               div,
  output logic [2*WIDTH-1:0] nxt
);
  logic [WIDTH:0] sum, t, diff;
  always_comb begin
    sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, mag} : '0);
    t    = work[2*WIDTH-1:WIDTH-1];
    diff = t - {1'b0, mag};
    nxt  = !div ? {sum, work[WIDTH-1:1]} :
           diff[WIDTH] ? {t[WIDTH-1:0], work[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/k_mult_div_unit.sv
// k_mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
module k_mult_div_unit
  import k_muldiv_pkg::*;
#(parameter int WIDTH = 32) (
  input logic clock,
  input logic reset_n,
  k_mult_div_unit_if.slave bus
);
  localparam logic [4:0] LAST = 5'(ITERS - 1);
  state_e state, nxt;
  op_e op_q;
  logic [WIDTH-1:0] a_q, b_q, mag, abs_a, abs_b, hi_q, lo_q, res_hi, res_lo, quo, rem;
  logic [2*WIDTH-1:0] work, step, prod;
  logic [4:0] cnt;
  logic neg_q, neg_r, done_q, div, sa, sb;
  k_muldiv_step #(.WIDTH(WIDTH)) u_step (.work(work), .mag(mag), .div(div), .nxt(step));
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (bus.start ? LOAD : IDLE) :
          state == LOAD ? RUN :
          state == RUN  ? (cnt == LAST ? FIX : RUN) : IDLE;
  always_comb begin
    div    = op_q[1];
    sa     = (op_q == OP_MULT || op_q == OP_DIV) && a_q[WIDTH-1];
    sb     = (op_q == OP_MULT || op_q == OP_DIV) && b_q[WIDTH-1];
    abs_a  = sa ? -a_q : a_q;
    abs_b  = sb ? -b_q : b_q;
    prod   = neg_q ? -work : work;
    quo    = neg_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
    rem    = neg_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
    // A zero divisor bypasses the sign fix and reports the raw dividend as remainder
    res_hi = !div ? prod[2*WIDTH-1:WIDTH] : b_q == '0 ? a_q : rem;
    res_lo = !div ? prod[WIDTH-1:0] : b_q == '0 ? '1 : quo;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      op_q   <= OP_MULTU;
      a_q    <= '0;
      b_q    <= '0;
      mag    <= '0;
      work   <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= state == FIX;
      if (state == IDLE && bus.start) begin
        op_q <= op_e'(bus.op);
        a_q  <= bus.K_in1;
        b_q  <= bus.K_in2;
      end
      if (state == LOAD) begin
        mag   <= div ? abs_b : abs_a;
        work  <= {{WIDTH{1'b0}}, div ? abs_a : abs_b};
        cnt   <= '0;
        neg_q <= sa ^ sb;
        neg_r <= sa;
      end
      if (state == RUN) begin
        work <= step;
        cnt  <= cnt + 5'd1;
      end
      if (state == FIX) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else begin
        if (bus.mt_hi) hi_q <= bus.mt_data;
        if (bus.mt_lo) lo_q <= bus.mt_data;
      end
    end
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
